sha3_padder: RTL

- Upstream stage of the `sha3` core.
- Accepts a message as a stream of 64-bit words with a valid/ready handshake.
- Assembles rate-sized blocks and applies SHA3 padding: domain byte 0x06 after the final message byte, 0x80 OR'd into the last rate byte.
- Presents each 1152-bit block on a valid/ready interface that drives `sha3_in`/`start`, with a last-block flag used to build the `sha3_ctrl` block count.

---
 rtl/sha3_padder_pkg.sv | 12 +
 rtl/sha3_padder_if.sv | 25 ++
 rtl/sha3_pad_mask.sv | 27 ++
 rtl/sha3_padder.sv | 99 +++++++++
 4 files changed

// File: rtl/sha3_padder_pkg.sv
// sha3_pkg: mode/state encodings, rate lookup and padding byte constants for sha3_padder
package sha3_pkg;
  typedef enum logic [1:0] {SHA3_224, SHA3_256, SHA3_384, SHA3_512} mode_e;
  typedef enum logic [1:0] {FILL, PAD, EMIT} state_e;
  localparam logic [7:0] DOM_SHA3  = 8'h06;
  localparam logic [7:0] DOM_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_END   = 8'h80;
  localparam logic [4:0] SHAKE_R   = 5'd17;
  function automatic logic [4:0] rate_words(mode_e m);
    return m == SHA3_224 ? 5'd18 : m == SHA3_256 ? 5'd17 : m == SHA3_384 ? 5'd13 : 5'd9;
  endfunction
endpackage

// File: rtl/sha3_padder_if.sv
// sha3_padder_if: message word stream in, padded rate block stream out
interface sha3_padder_if #(
  parameter int BLK_W  = 1152,
  parameter int WORD_W = 64,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic [3:0]        in_bytes;
  logic              blk_valid;
  logic              blk_ready;
  logic [BLK_W-1:0]  blk_data;
  logic              blk_last;
  logic [CNT_W-1:0]  blk_idx;
  modport master (
    output in_valid, in_data, in_last, in_bytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last, blk_idx
  );
  modport slave (
    input  in_valid, in_data, in_last, in_bytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last, blk_idx
  );
endinterface

// File: rtl/sha3_pad_mask.sv
// sha3_pad_mask: byte-enable mask for the current word and domain/end padding overlay for the block
module sha3_pad_mask import sha3_pkg::*; #(
  parameter int BLK_W  = 1152,
  parameter int WORD_W = 64
) (
  input  logic [4:0]        ptr,
  input  logic [3:0]        bytes,
  input  logic              last,
  input  logic [4:0]        r,
  input  logic [7:0]        dom,
  output logic [WORD_W-1:0] mask,
  output logic [BLK_W-1:0]  overlay,
  output logic              pad
);
  logic [3:0] nb;
  logic [7:0] dom_off;
  logic [7:0] end_off;
  always_comb begin
    nb = !last || bytes > 4'd8 ? 4'd8 : bytes;
    // a full last word that closes the block defers padding to a separate block
    pad = last && !(nb == 4'd8 && ptr == r - 5'd1);
    dom_off = {ptr, 3'b0} + {4'b0, nb};
    end_off = {r, 3'b0} - 8'd1;
    mask = ~({WORD_W{1'b1}} >> {nb, 3'b0});
    overlay = pad ? ({dom, {BLK_W-8{1'b0}}} >> {dom_off, 3'b0}) | ({PAD_END, {BLK_W-8{1'b0}}} >> {end_off, 3'b0}) : '0;
  end
endmodule

// File: rtl/sha3_padder.sv
// sha3_padder: packs 64-bit message words into SHA3 rate blocks with domain/end padding.
// Optional SHAKE256 domain (port shake) when SHA3_PADDER_SHAKE_EN is defined.
module sha3_padder import sha3_pkg::*; #(
  parameter int BLK_W  = 1152,
  parameter int WORD_W = 64,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] mode,
`ifdef SHA3_PADDER_SHAKE_EN
  input  logic       shake,
`endif
  sha3_padder_if.slave bus
);
  state_e            state, state_n;
  mode_e             mode_q, m_eff;
  logic [4:0]        ptr, r, ptr_m;
  logic [7:0]        dom;
  logic [3:0]        bytes_m;
  logic              first, acc, done, pad, pad_pending, last_m, blk_last;
  logic [WORD_W-1:0] mask;
  logic [BLK_W-1:0]  overlay, placed, blk;
  logic [CNT_W-1:0]  idx;
`ifdef SHA3_PADDER_SHAKE_EN
  logic              shake_q, sh;
`endif
  // the first word of a message uses the live mode, later words the latched one
  always_comb begin
    first = state == FILL && ptr == '0 && idx == '0;
    m_eff = first ? mode_e'(mode) : mode_q;
`ifdef SHA3_PADDER_SHAKE_EN
    sh = first ? shake : shake_q;
    r = sh ? SHAKE_R : rate_words(m_eff);
    dom = sh ? DOM_SHAKE : DOM_SHA3;
`else
    r = rate_words(m_eff);
    dom = DOM_SHA3;
`endif
    acc = state == FILL && bus.in_valid;
    done = acc && (bus.in_last || ptr == r - 5'd1);
    ptr_m = state == PAD ? '0 : ptr;
    bytes_m = state == PAD ? '0 : bus.in_bytes;
    last_m = state == PAD || bus.in_last;
    placed = {bus.in_data & mask, {BLK_W-WORD_W{1'b0}}} >> {ptr, 6'b0};
  end
  sha3_pad_mask #(.BLK_W(BLK_W), .WORD_W(WORD_W)) u_mask (
    .ptr(ptr_m), .bytes(bytes_m), .last(last_m), .r(r), .dom(dom),
    .mask(mask), .overlay(overlay), .pad(pad)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= FILL;
    else state <= state_n;
  always_comb
    state_n = state == FILL ? (done ? EMIT : FILL) :
              state == PAD  ? EMIT :
              bus.blk_ready ? (pad_pending ? PAD : FILL) : EMIT;
  always_comb begin
    bus.in_ready = state == FILL;
    bus.blk_valid = state == EMIT;
    bus.blk_data = blk;
    bus.blk_last = blk_last;
    bus.blk_idx = idx;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk <= '0;
      ptr <= '0;
      idx <= '0;
      blk_last <= 1'b0;
      pad_pending <= 1'b0;
      mode_q <= SHA3_224;
`ifdef SHA3_PADDER_SHAKE_EN
      shake_q <= 1'b0;
`endif
    end else if (acc) begin
      blk <= blk | placed | overlay;
      ptr <= done ? '0 : ptr + 5'd1;
      if (first) begin
        mode_q <= mode_e'(mode);
`ifdef SHA3_PADDER_SHAKE_EN
        shake_q <= shake;
`endif
      end
      if (done) begin
        blk_last <= pad;
        pad_pending <= bus.in_last && !pad;
      end
    end else if (state == PAD) begin
      blk <= overlay;
      blk_last <= 1'b1;
      pad_pending <= 1'b0;
    end else if (state == EMIT && bus.blk_ready) begin
      blk <= '0;
      blk_last <= 1'b0;
      idx <= blk_last ? '0 : idx + CNT_W'(1);
    end
  end
endmodule
